// File: rtl/jtdsp16_pkg.sv
// Shared constants and state encoding for the DSP16 do/redo loop cache.
package jtdsp16_pkg;

    localparam int unsigned DEPTH     = 15;
    localparam int unsigned DW        = 16;
    localparam int unsigned AW        = 4;
    localparam int unsigned NW        = 4;
    localparam int unsigned KW        = 7;
    localparam int unsigned DO_NI_MSB = 10;
    localparam int unsigned DO_NI_LSB = 7;
    localparam int unsigned DO_K_MSB  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        LOOP = 2'd2
    } do_state_e;

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// Loop-body register file: one cen-gated synchronous write port, one asynchronous read port.
module jtdsp16_cache_mem #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset so a later redo can replay them.
    always_ff @(posedge clk) begin
        if (cen && we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jtdsp16_do_cache.sv
// DSP16 do/redo loop engine: records the loop body on the first pass, then replays it
// from the cache with the program counter frozen for the remaining passes.
module jtdsp16_do_cache
    import jtdsp16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          do_start,
    input  logic [10:0]   do_data,
    input  logic          ifetch,
    input  logic [DW-1:0] rom_dout,
    output logic [DW-1:0] cache_dout,
    output logic          cache_en,
    output logic          pc_hold,
    output logic          do_busy,
    output logic          no_int,
    output logic          fault
);

    do_state_e     state_q, state_d;
    logic [NW-1:0] ni_q, ni_d;
    logic [KW-1:0] k_q, k_d, iter_q, iter_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          fault_d;
    logic [NW-1:0] do_ni, ni_last;
    logic [KW-1:0] do_k;
    logic [DW-1:0] rd_data;
    logic          we_c;

    assign do_ni   = do_data[DO_NI_MSB:DO_NI_LSB];
    assign do_k    = do_data[DO_K_MSB:0];
    assign ni_last = NW'(ni_q - 4'd1);
    assign we_c    = (state_q == FILL) && ifetch;

    jtdsp16_cache_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_mem (
        .clk   (clk),
        .cen   (cen),
        .we    (we_c),
        .waddr (wr_q),
        .wdata (rom_dout),
        .raddr (rd_q),
        .rdata (rd_data)
    );

    assign cache_dout = cache_en ? rd_data : '0;

    // Next-state, pointer and iteration bookkeeping.
    always_comb begin
        state_d = state_q;
        ni_d    = ni_q;
        k_d     = k_q;
        iter_d  = iter_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (do_start) begin
                    if (do_ni != '0) begin
                        ni_d    = do_ni;
                        k_d     = do_k;
                        wr_d    = '0;
                        state_d = FILL;
                    end else if (ni_q == '0) begin
                        fault_d = 1'b1;
                    end else if (do_k != '0) begin
                        iter_d  = do_k;
                        rd_d    = '0;
                        state_d = LOOP;
                    end
                end
            end
            FILL: begin
                fault_d = do_start;
                if (ifetch) begin
                    if (wr_q == ni_last) begin
                        if (k_q >= 7'd2) begin
                            iter_d  = KW'(k_q - 7'd1);
                            rd_d    = '0;
                            state_d = LOOP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        wr_d = AW'(wr_q + 4'd1);
                    end
                end
            end
            LOOP: begin
                fault_d = do_start;
                if (ifetch) begin
                    if (rd_q == ni_last) begin
                        rd_d = '0;
                        if (iter_q == 7'd1) state_d = IDLE;
                        else                iter_d  = KW'(iter_q - 7'd1);
                    end else begin
                        rd_d = AW'(rd_q + 4'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ni_q     <= '0;
            k_q      <= '0;
            iter_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cache_en <= 1'b0;
            pc_hold  <= 1'b0;
            do_busy  <= 1'b0;
            no_int   <= 1'b0;
            fault    <= 1'b0;
        end else if (cen) begin
            state_q  <= state_d;
            ni_q     <= ni_d;
            k_q      <= k_d;
            iter_q   <= iter_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cache_en <= (state_d == LOOP);
            pc_hold  <= (state_d == LOOP);
            do_busy  <= (state_d != IDLE);
            no_int   <= (state_d != IDLE);
            fault    <= fault_d;
        end
    end

endmodule
